// File: rtl/rom68k_arb.sv
// ============================================================================
// Module   : rom68k_arb
// Purpose  : Round-robin two-port arbiter/sequencer in front of the 68k code ROM
// Revision : 1.0
// ============================================================================
`default_nettype none

module rom68k_arb #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic [ADDR_W-1:0] p0_addr,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_data,
  input  logic              p1_req,
  input  logic [ADDR_W-1:0] p1_addr,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_data,
  output logic              p_err,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_ack,
  input  logic [DATA_W-1:0] rom_data
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_WAIT  = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] p0_data_q, p0_data_d;
  logic [DATA_W-1:0] p1_data_q, p1_data_d;
  logic              w_win;

  // On a tie the port that was not served last wins; otherwise the sole requester.
  always_comb begin
    if (p0_req && p1_req) begin
      w_win = ~last_q;
    end else begin
      w_win = p1_req;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    p0_data_d = p0_data_q;
    p1_data_d = p1_data_q;

    case (state_q)
      c_IDLE: begin
        if (p0_req || p1_req) begin
          gnt_d   = w_win;
          addr_d  = w_win ? p1_addr : p0_addr;
          state_d = c_ISSUE;
        end
      end
      c_ISSUE: begin
        cnt_d   = 8'd0;
        state_d = c_WAIT;
      end
      c_WAIT: begin
        if (rom_ack) begin
          if (gnt_q) begin
            p1_data_d = rom_data;
          end else begin
            p0_data_d = rom_data;
          end
          state_d = c_DONE;
        end else if (cnt_q == c_CNT_LAST) begin
          if (gnt_q) begin
            p1_data_d = '1;
          end else begin
            p0_data_d = '1;
          end
          err_d   = 1'b1;
          state_d = c_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      c_DONE: begin
        err_d   = 1'b0;
        last_d  = gnt_q;
        state_d = c_IDLE;
      end
      default: begin
        state_d = c_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= c_IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      addr_q    <= '0;
      cnt_q     <= 8'd0;
      err_q     <= 1'b0;
      p0_data_q <= '0;
      p1_data_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      p0_data_q <= p0_data_d;
      p1_data_q <= p1_data_d;
    end
  end

  // Every output is a register or a pure decode of registered state.
  assign rom_req  = (state_q == c_ISSUE);
  assign rom_addr = addr_q;
  assign p0_ack   = (state_q == c_DONE) && !gnt_q;
  assign p1_ack   = (state_q == c_DONE) &&  gnt_q;
  assign p_err    = (state_q == c_DONE) &&  err_q;
  assign p0_data  = p0_data_q;
  assign p1_data  = p1_data_q;

endmodule

`default_nettype wire
